// File: rtl/pipeline_adder_stall_pkg.sv
// Shared constants for the four-stage stalling adder pipeline.
//   NUM_STAGES : number of pipeline stages; the operand is split into this many chunks
//   STG1..STG4 : bit index of each stage inside the stall/refresh vectors
package pipeline_adder_stall_pkg;

    localparam int unsigned NUM_STAGES = 4;

    localparam int unsigned STG1 = 0;
    localparam int unsigned STG2 = 1;
    localparam int unsigned STG3 = 2;
    localparam int unsigned STG4 = 3;

endpackage

// File: rtl/pipeline_adder_stall_stage.sv
// One stage of the chunked adder pipeline. It holds a valid bit, the carry out
// of its chunk and a data word, and it adds one CHUNK-wide slice per transfer.
//   clk, rst     : clock, synchronous active-high reset
//   valid_in     : upstream offers an item this cycle (already qualified by upstream ready_go)
//   op_a, op_b   : operand chunk consumed by this stage
//   carry_in     : carry from the previous chunk
//   pass_in      : partial sum and unconsumed operand chunks, carried through unchanged
//   stall        : hold the current item and do not forward it
//   refresh      : invalidate this stage at the next edge (wins over load and stall)
//   allow_next   : downstream stage can accept an item this cycle
//   allowin_c    : this stage can accept an item this cycle (combinational)
//   valid        : this stage holds a live item
//   carry        : carry out of this stage's chunk
//   word         : {chunk sum, pass_in} captured at the last load
module adder_pipe_stage #(
    parameter int unsigned CHUNK  = 8,
    parameter int unsigned PASS_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [CHUNK-1:0]        op_a,
    input  logic [CHUNK-1:0]        op_b,
    input  logic                    carry_in,
    input  logic [PASS_W-1:0]       pass_in,
    input  logic                    stall,
    input  logic                    refresh,
    input  logic                    allow_next,
    output logic                    allowin_c,
    output logic                    valid,
    output logic                    carry,
    output logic [PASS_W+CHUNK-1:0] word
);

    logic             ready_go;
    logic [CHUNK:0]   add_c;

    // Empty stages always accept; full ones only when their item can move on.
    assign ready_go  = !stall;
    assign allowin_c = !valid || (ready_go && allow_next);

    assign add_c = (CHUNK+1)'(op_a) + (CHUNK+1)'(op_b) + (CHUNK+1)'(carry_in);

    // Refresh clears valid even when a new item is being loaded in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            carry <= 1'b0;
            word  <= '0;
        end else begin
            if (refresh) begin
                valid <= 1'b0;
            end else if (allowin_c) begin
                valid <= valid_in;
            end
            if (allowin_c) begin
                carry <= add_c[CHUNK];
                word  <= {add_c[CHUNK-1:0], pass_in};
            end
        end
    end

endmodule

// File: rtl/pipeline_adder_stall.sv
// Four-stage pipelined WIDTH-bit adder with valid/allowin handshake, per-stage
// stall and per-stage refresh. Carry ripples one CHUNK per stage.
//   clk, rst  : clock, synchronous active-high reset
//   validin   : operand pair offered;  a, b, cin : operands and carry-in
//   allowin   : adder accepts input this cycle (combinational)
//   stall     : stall[k] holds stage k+1;  refresh : refresh[k] invalidates stage k+1
//   out_allow : downstream accepts a result this cycle
//   validout, sum, cout : registered result of the last stage
module pipeline_adder_stall
    import pipeline_adder_stall_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  validin,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic                  cin,
    output logic                  allowin,
    input  logic [NUM_STAGES-1:0] stall,
    input  logic [NUM_STAGES-1:0] refresh,
    input  logic                  out_allow,
    output logic                  validout,
    output logic [WIDTH-1:0]      sum,
    output logic                  cout
);

    localparam int unsigned CHUNK = WIDTH / NUM_STAGES;

    // Word layout per stage (MSB first):
    //   stage 1 : s1 | a4 a3 a2 | b4 b3 b2
    //   stage 2 : s2 s1 | a4 a3 | b4 b3
    //   stage 3 : s3 s2 s1 | a4 | b4
    //   stage 4 : s4 s3 s2 s1   (the final sum)
    localparam int unsigned W1 = 7 * CHUNK;
    localparam int unsigned W2 = 6 * CHUNK;
    localparam int unsigned W3 = 5 * CHUNK;

    logic [NUM_STAGES-1:0] allow_c;
    logic [NUM_STAGES-1:0] valid_q;
    logic [NUM_STAGES-1:0] carry_q;
    logic [W1-1:0]         word1;
    logic [W2-1:0]         word2;
    logic [W3-1:0]         word3;
    logic [WIDTH-1:0]      word4;

    assign allowin = allow_c[STG1];

    adder_pipe_stage #(.CHUNK(CHUNK), .PASS_W(6 * CHUNK)) u_stage1 (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (validin),
        .op_a       (a[CHUNK-1:0]),
        .op_b       (b[CHUNK-1:0]),
        .carry_in   (cin),
        .pass_in    ({a[WIDTH-1:CHUNK], b[WIDTH-1:CHUNK]}),
        .stall      (stall[STG1]),
        .refresh    (refresh[STG1]),
        .allow_next (allow_c[STG2]),
        .allowin_c  (allow_c[STG1]),
        .valid      (valid_q[STG1]),
        .carry      (carry_q[STG1]),
        .word       (word1)
    );

    adder_pipe_stage #(.CHUNK(CHUNK), .PASS_W(5 * CHUNK)) u_stage2 (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_q[STG1] && !stall[STG1]),
        .op_a       (word1[3*CHUNK +: CHUNK]),
        .op_b       (word1[0 +: CHUNK]),
        .carry_in   (carry_q[STG1]),
        .pass_in    ({word1[6*CHUNK +: CHUNK], word1[4*CHUNK +: 2*CHUNK],
                      word1[CHUNK +: 2*CHUNK]}),
        .stall      (stall[STG2]),
        .refresh    (refresh[STG2]),
        .allow_next (allow_c[STG3]),
        .allowin_c  (allow_c[STG2]),
        .valid      (valid_q[STG2]),
        .carry      (carry_q[STG2]),
        .word       (word2)
    );

    adder_pipe_stage #(.CHUNK(CHUNK), .PASS_W(4 * CHUNK)) u_stage3 (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_q[STG2] && !stall[STG2]),
        .op_a       (word2[2*CHUNK +: CHUNK]),
        .op_b       (word2[0 +: CHUNK]),
        .carry_in   (carry_q[STG2]),
        .pass_in    ({word2[4*CHUNK +: 2*CHUNK], word2[3*CHUNK +: CHUNK],
                      word2[CHUNK +: CHUNK]}),
        .stall      (stall[STG3]),
        .refresh    (refresh[STG3]),
        .allow_next (allow_c[STG4]),
        .allowin_c  (allow_c[STG3]),
        .valid      (valid_q[STG3]),
        .carry      (carry_q[STG3]),
        .word       (word3)
    );

    adder_pipe_stage #(.CHUNK(CHUNK), .PASS_W(3 * CHUNK)) u_stage4 (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_q[STG3] && !stall[STG3]),
        .op_a       (word3[CHUNK +: CHUNK]),
        .op_b       (word3[0 +: CHUNK]),
        .carry_in   (carry_q[STG3]),
        .pass_in    (word3[2*CHUNK +: 3*CHUNK]),
        .stall      (stall[STG4]),
        .refresh    (refresh[STG4]),
        .allow_next (out_allow),
        .allowin_c  (allow_c[STG4]),
        .valid      (valid_q[STG4]),
        .carry      (carry_q[STG4]),
        .word       (word4)
    );

    // Last-stage registers drive the outputs directly.
    assign validout = valid_q[STG4];
    assign sum      = word4;
    assign cout     = carry_q[STG4];

endmodule

// File: tb/tb_pipeline_adder_stall.sv
// Directed self-checking bench for pipeline_adder_stall (WIDTH = 32).
module tb_pipeline_adder_stall;

    logic        clk;
    logic        rst;
    logic        validin;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        allowin;
    logic [3:0]  stall;
    logic [3:0]  refresh;
    logic        out_allow;
    logic        validout;
    logic [31:0] sum;
    logic        cout;

    int checks = 0;
    int errors = 0;

    pipeline_adder_stall #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .validin   (validin),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .allowin   (allowin),
        .stall     (stall),
        .refresh   (refresh),
        .out_allow (out_allow),
        .validout  (validout),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; validin = 1'b0; a = '0; b = '0; cin = 1'b0;
        stall = '0; refresh = '0; out_allow = 1'b1;
        step();
        step();
        checks++;
        if (validout !== 1'b0) begin errors++; $display("FAIL reset_validout: got %b expected 0", validout); end
        checks++;
        if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h expected 00000000", sum); end
        checks++;
        if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
        rst = 1'b0;
        #1;
        checks++;
        if (allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b expected 1", allowin); end
    endtask

    task automatic test_carry();
        validin = 1'b1; a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0;
        #1;
        checks++;
        if (allowin !== 1'b1) begin errors++; $display("FAIL carry_allowin: got %b expected 1", allowin); end
        step();
        validin = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (validout !== 1'b0) begin errors++; $display("FAIL carry_early c+%0d: got validout %b expected 0", i, validout); end
            step();
        end
        checks++;
        if (validout !== 1'b1 || sum !== 32'h0000_0100 || cout !== 1'b0) begin
            errors++;
            $display("FAIL carry_result: got v=%b sum=%h cout=%b expected v=1 sum=00000100 cout=0", validout, sum, cout);
        end
        step();
        checks++;
        if (validout !== 1'b0) begin errors++; $display("FAIL carry_after: got validout %b expected 0", validout); end
    endtask

    task automatic test_ripple();
        logic [31:0] va [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_FFFF};
        logic [31:0] vb [3] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_FFFF};
        logic        vc [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] es [3] = '{32'h0000_0000, 32'h0000_0000, 32'h0001_FFFF};
        logic        ec [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            validin = 1'b1; a = va[i]; b = vb[i]; cin = vc[i];
            step();
        end
        validin = 1'b0;
        checks++;
        if (validout !== 1'b0) begin errors++; $display("FAIL ripple_early: got validout %b expected 0", validout); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (validout !== 1'b1 || sum !== es[i] || cout !== ec[i]) begin
                errors++;
                $display("FAIL ripple_item%0d: got v=%b sum=%h cout=%b expected v=1 sum=%h cout=%b",
                         i, validout, sum, cout, es[i], ec[i]);
            end
        end
        step();
        checks++;
        if (validout !== 1'b0) begin errors++; $display("FAIL ripple_after: got validout %b expected 0", validout); end
    endtask

    task automatic test_stream();
        int k;
        for (int t = 0; t < 13; t++) begin
            if (t < 8) begin
                validin = 1'b1; a = 32'(t + 1); b = 32'(16 * (t + 1));
            end else begin
                validin = 1'b0;
            end
            cin = 1'b0;
            #1;
            if (t < 8) begin
                checks++;
                if (allowin !== 1'b1) begin errors++; $display("FAIL stream_allowin t=%0d: got %b expected 1", t, allowin); end
            end
            step();
            k = t + 1 - 4;
            checks++;
            if (k >= 0 && k < 8) begin
                if (validout !== 1'b1 || sum !== 32'(17 * (k + 1)) || cout !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_item%0d: got v=%b sum=%h cout=%b expected v=1 sum=%h cout=0",
                             k, validout, sum, cout, 32'(17 * (k + 1)));
                end
            end else if (validout !== 1'b0) begin
                errors++;
                $display("FAIL stream_idle cycle %0d: got validout %b expected 0", t + 1, validout);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] es [4] = '{32'h1101_0101, 32'h1202_0203, 32'h1303_0303, 32'h1404_0405};
        int sent = 0;
        out_allow = 1'b0;
        for (int t = 0; t < 6; t++) begin
            validin = 1'b1;
            a = 32'h0101_0101 * 32'(sent + 1);
            b = 32'h1000_0000;
            cin = 1'(sent & 1);
            #1;
            checks++;
            if (allowin !== (t < 4)) begin
                errors++;
                $display("FAIL bp_allowin t=%0d: got %b expected %b", t, allowin, (t < 4));
            end
            if (allowin === 1'b1) sent++;
            step();
        end
        checks++;
        if (sent != 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", sent); end
        checks++;
        if (validout !== 1'b1 || sum !== es[0]) begin
            errors++;
            $display("FAIL bp_head: got v=%b sum=%h expected v=1 sum=%h", validout, sum, es[0]);
        end
        validin = 1'b0;
        out_allow = 1'b1;
        #1;
        checks++;
        if (allowin !== 1'b1) begin errors++; $display("FAIL bp_release_allowin: got %b expected 1", allowin); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (validout !== 1'b1 || sum !== es[i] || cout !== 1'b0) begin
                errors++;
                $display("FAIL bp_item%0d: got v=%b sum=%h cout=%b expected v=1 sum=%h cout=0",
                         i, validout, sum, cout, es[i]);
            end
            step();
        end
        checks++;
        if (validout !== 1'b0) begin errors++; $display("FAIL bp_drained: got validout %b expected 0", validout); end
    endtask

    // Items sum to their index with a carry rippling through every chunk.
    task automatic test_stall();
        int exp_cyc [6] = '{4, 5, 9, 10, 11, 12};
        int sent = 0;
        int got = 0;
        out_allow = 1'b1;
        for (int t = 0; t < 16; t++) begin
            stall   = (t >= 4 && t <= 6) ? 4'b0010 : 4'b0000;
            validin = (sent < 6);
            a = 32'hFFFF_FF00 + 32'(sent);
            b = 32'h0000_0100;
            cin = 1'b0;
            #1;
            if (t >= 4 && t <= 6) begin
                checks++;
                if (allowin !== 1'b0) begin errors++; $display("FAIL stall_allowin t=%0d: got %b expected 0", t, allowin); end
            end
            if (validin && allowin === 1'b1) sent++;
            step();
            if (validout === 1'b1) begin
                checks++;
                if (got >= 6) begin
                    errors++;
                    $display("FAIL stall_extra cycle %0d: got sum=%h expected no result", t + 1, sum);
                end else if (sum !== 32'(got) || cout !== 1'b1 || (t + 1) != exp_cyc[got]) begin
                    errors++;
                    $display("FAIL stall_item%0d: got sum=%h cout=%b cycle %0d expected sum=%h cout=1 cycle %0d",
                             got, sum, cout, t + 1, 32'(got), exp_cyc[got]);
                end
                got++;
            end
        end
        stall = '0;
        validin = 1'b0;
        checks++;
        if (got != 6) begin errors++; $display("FAIL stall_count: got %0d results expected 6", got); end
    endtask

    // Stage 3 is held and refreshed in the same cycle, so item 1 vanishes.
    task automatic test_refresh();
        int exp_item [5] = '{0, 2, 3, 4, 5};
        int exp_cyc  [5] = '{4, 7, 8, 9, 10};
        int sent = 0;
        int got = 0;
        out_allow = 1'b1;
        for (int t = 0; t < 15; t++) begin
            stall   = (t == 4) ? 4'b0100 : 4'b0000;
            refresh = (t == 4) ? 4'b0100 : 4'b0000;
            validin = (sent < 6);
            a = 32'hFFFF_FF00 + 32'(sent);
            b = 32'h0000_0100;
            cin = 1'b0;
            #1;
            if (t == 4) begin
                checks++;
                if (allowin !== 1'b0) begin errors++; $display("FAIL refresh_allowin: got %b expected 0", allowin); end
            end
            if (validin && allowin === 1'b1) sent++;
            step();
            if (validout === 1'b1) begin
                checks++;
                if (got >= 5) begin
                    errors++;
                    $display("FAIL refresh_extra cycle %0d: got sum=%h expected no result", t + 1, sum);
                end else if (sum !== 32'(exp_item[got]) || cout !== 1'b1 || (t + 1) != exp_cyc[got]) begin
                    errors++;
                    $display("FAIL refresh_out%0d: got sum=%h cout=%b cycle %0d expected sum=%h cout=1 cycle %0d",
                             got, sum, cout, t + 1, 32'(exp_item[got]), exp_cyc[got]);
                end
                got++;
            end
        end
        stall = '0;
        refresh = '0;
        validin = 1'b0;
        checks++;
        if (got != 5) begin errors++; $display("FAIL refresh_count: got %0d results expected 5", got); end
    endtask

    task automatic test_reset_midflight();
        out_allow = 1'b1;
        for (int t = 0; t < 4; t++) begin
            validin = 1'b1; a = 32'h1234_5678 + 32'(t); b = 32'h1111_1111; cin = 1'b0;
            step();
        end
        checks++;
        if (validout !== 1'b1 || sum !== 32'h2345_6789) begin
            errors++;
            $display("FAIL rstmid_head: got v=%b sum=%h expected v=1 sum=23456789", validout, sum);
        end
        rst = 1'b1;
        validin = 1'b1; a = 32'h1234_567C;
        step();
        rst = 1'b0;
        validin = 1'b0;
        checks++;
        if (validout !== 1'b0 || sum !== 32'h0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got v=%b sum=%h cout=%b expected v=0 sum=00000000 cout=0", validout, sum, cout);
        end
        #1;
        checks++;
        if (allowin !== 1'b1) begin errors++; $display("FAIL rstmid_allowin: got %b expected 1", allowin); end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (validout !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_stale cycle %0d: got validout %b sum=%h expected validout 0", i, validout, sum);
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_ripple();
        test_stream();
        test_backpressure();
        test_stall();
        test_refresh();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
